// File: rtl/cdb_rr_pkg.sv
// Shared CDB definitions: default sizing, broadcast packet types and width helpers
// used by the multi-lane round-robin common data bus.
package cdb_rr_pkg;

  localparam int unsigned NUM_FU_DEF  = 8;
  localparam int unsigned NUM_CDB     = 2;
  localparam int unsigned TAG_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF  = 32;

  // One broadcast lane as seen by RS, ROB and map table.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  rob_tag;
    logic [DATA_W_DEF-1:0] value;
  } cdb_packet_t;

  // FU side request bundle, widened to all FUs.
  typedef struct packed {
    logic [NUM_FU_DEF-1:0]                 done;
    logic [NUM_FU_DEF-1:0][TAG_W_DEF-1:0]  rob_tag;
    logic [NUM_FU_DEF-1:0][DATA_W_DEF-1:0] value;
  } fu_cdb_packet_t;

  // CDB side response: per-FU acks plus the broadcast lanes.
  typedef struct packed {
    logic [NUM_FU_DEF-1:0]            ack;
    cdb_packet_t [NUM_CDB-1:0]        lanes;
  } cdb_fu_packet_t;

  // Pointer width that stays legal for a single requester.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Enough bits to count 0..k grants.
  function automatic int unsigned cnt_width(input int unsigned k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Combinational round-robin multi-grant selector: grants up to K requesters scanning
// from ptr upward with wrap, reporting which requester lands on each lane.
module rr_multi_select
  import cdb_rr_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned K  = 2,
  parameter int unsigned PW = ptr_width(N),
  parameter int unsigned CW = cnt_width(K)
) (
  input  logic [N-1:0]         req,
  input  logic [PW-1:0]        ptr,
  output logic [N-1:0]         grant,
  output logic [K-1:0][PW-1:0] lane_idx,
  output logic [CW-1:0]        grant_cnt
);

  int unsigned cnt;

  // Scan offsets j in priority order; inner loop keeps every index constant.
  always_comb begin
    grant    = '0;
    lane_idx = '0;
    cnt      = 0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned n = 0; n < N; n++) begin
        if ((n == (32'(ptr) + j) % N) && req[n] && (cnt < K)) begin
          grant[n] = 1'b1;
          for (int unsigned k = 0; k < K; k++) begin
            if (k == cnt) begin
              lane_idx[k] = PW'(n);
            end
          end
          cnt = cnt + 1;
        end
      end
    end
    grant_cnt = CW'(cnt);
  end

endmodule

// File: rtl/cdb_rr.sv
// Multi-lane common data bus: round-robin grants up to NUM_CDB finished FUs per cycle,
// acks them combinationally and broadcasts their tag/value on registered lanes.
module cdb_rr
  import cdb_rr_pkg::*;
#(
  parameter int unsigned NUM_FU  = NUM_FU_DEF,
  parameter int unsigned NUM_CDB = cdb_rr_pkg::NUM_CDB,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [NUM_FU-1:0]              fu_done,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_rob_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_value,
  output logic [NUM_FU-1:0]              fu_ack,
  output logic [NUM_CDB-1:0]             cdb_valid,
  output logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_rob_tag,
  output logic [NUM_CDB-1:0][DATA_W-1:0] cdb_value
);

  localparam int unsigned PW = ptr_width(NUM_FU);
  localparam int unsigned CW = cnt_width(NUM_CDB);

  logic                            flush;
  logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]               grant;
  logic [NUM_CDB-1:0][PW-1:0]      lane_idx;
  logic [CW-1:0]                   grant_cnt;
  logic [NUM_CDB-1:0]              lane_vld;
  logic [PW-1:0]                   last_idx;

  logic [NUM_CDB-1:0]              valid_q, valid_d;
  logic [NUM_CDB-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_CDB-1:0][DATA_W-1:0]  value_q, value_d;

  assign flush = reset | clear;

  rr_multi_select #(
    .N  (NUM_FU),
    .K  (NUM_CDB),
    .PW (PW),
    .CW (CW)
  ) u_select (
    .req       (fu_done),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .lane_idx  (lane_idx),
    .grant_cnt (grant_cnt)
  );

  // Acks are suppressed during flush so no FU retires a result that would be dropped.
  always_comb begin
    fu_ack = flush ? '0 : grant;
  end

  // Lane mux: grant n in scan order drives lane n; unused lanes broadcast zeros.
  always_comb begin
    lane_vld = '0;
    valid_d  = '0;
    tag_d    = '0;
    value_d  = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      lane_vld[k] = (32'(grant_cnt) > k);
      if (lane_vld[k]) begin
        valid_d[k] = 1'b1;
        for (int unsigned n = 0; n < NUM_FU; n++) begin
          if (32'(lane_idx[k]) == n) begin
            tag_d[k]   = fu_rob_tag[n];
            value_d[k] = fu_value[n];
          end
        end
      end
    end
  end

  // Priority moves just past the last granted FU; holds when nothing was granted.
  always_comb begin
    last_idx = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (lane_vld[k]) begin
        last_idx = lane_idx[k];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_cnt != '0) begin
      rr_ptr_d = (32'(last_idx) == NUM_FU - 1) ? '0 : last_idx + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
      value_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      value_q  <= value_d;
    end
  end

  assign cdb_valid   = valid_q;
  assign cdb_rob_tag = tag_q;
  assign cdb_value   = value_q;

endmodule

// File: tb/tb_cdb_rr.sv
// Self-checking bench for cdb_rr with NUM_FU=4, NUM_CDB=2: table of vectors, lane
// scoreboard and a fairness sequence.
module tb_cdb_rr;

  localparam int unsigned NF = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 32;

  logic                   clock;
  logic                   reset;
  logic                   clear;
  logic [NF-1:0]          fu_done;
  logic [NF-1:0][TW-1:0]  fu_rob_tag;
  logic [NF-1:0][DW-1:0]  fu_value;
  logic [NF-1:0]          fu_ack;
  logic [NC-1:0]          cdb_valid;
  logic [NC-1:0][TW-1:0]  cdb_rob_tag;
  logic [NC-1:0][DW-1:0]  cdb_value;

  cdb_rr #(
    .NUM_FU  (NF),
    .NUM_CDB (NC),
    .TAG_W   (TW),
    .DATA_W  (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .fu_done     (fu_done),
    .fu_rob_tag  (fu_rob_tag),
    .fu_value    (fu_value),
    .fu_ack      (fu_ack),
    .cdb_valid   (cdb_valid),
    .cdb_rob_tag (cdb_rob_tag),
    .cdb_value   (cdb_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            rst;
    logic            clr;
    logic [NF-1:0]   done;
    logic [TW-1:0]   tag_base;
    logic [DW-1:0]   val_base;
    logic [NF-1:0]   exp_ack;
    int              exp_ptr;
  } vec_t;

  typedef struct packed {
    logic [NC-1:0]         valid;
    logic [NC-1:0][TW-1:0] tag;
    logic [NC-1:0][DW-1:0] val;
  } lanes_t;

  vec_t   vecs[$];
  lanes_t sb[$];
  int     checks   = 0;
  int     failures = 0;
  int     mdl_ptr  = 0;

  task automatic add_vec(input logic rst, input logic clr, input logic [NF-1:0] done,
                         input logic [TW-1:0] tb, input logic [DW-1:0] vb,
                         input logic [NF-1:0] ack, input int ptr);
    vec_t v;
    v.rst = rst; v.clr = clr; v.done = done; v.tag_base = tb; v.val_base = vb;
    v.exp_ack = ack; v.exp_ptr = ptr;
    vecs.push_back(v);
  endtask

  // Independent reference: first NC requesters scanning up from ptr with wrap.
  function automatic logic [NF-1:0] model_grant(input logic [NF-1:0] done, input int ptr);
    logic [NF-1:0] g = '0;
    int            n = 0;
    for (int j = 0; j < NF; j++) begin
      int idx = (ptr + j) % NF;
      if (done[idx] && n < NC) begin
        g[idx] = 1'b1;
        n++;
      end
    end
    return g;
  endfunction

  task automatic step(input logic rst, input logic clr, input logic [NF-1:0] done,
                      input logic [TW-1:0] tb, input logic [DW-1:0] vb,
                      input logic [NF-1:0] exp_ack, input bit chk_ptr, input int exp_ptr,
                      input string name);
    lanes_t e;
    lanes_t got;
    int     n    = 0;
    int     last = 0;
    @(negedge clock);
    reset   = rst;
    clear   = clr;
    fu_done = done;
    for (int i = 0; i < NF; i++) begin
      fu_rob_tag[i] = tb + TW'(i);
      fu_value[i]   = vb + DW'(i);
    end
    #1;
    checks++;
    if (fu_ack !== exp_ack) begin
      failures++;
      $display("FAIL %s ack: got %b want %b", name, fu_ack, exp_ack);
    end
    e = '0;
    for (int j = 0; j < NF; j++) begin
      int idx = (mdl_ptr + j) % NF;
      if (exp_ack[idx] && n < NC) begin
        e.valid[n] = 1'b1;
        e.tag[n]   = tb + TW'(idx);
        e.val[n]   = vb + DW'(idx);
        last       = idx;
        n++;
      end
    end
    sb.push_back(e);
    if (rst || clr) mdl_ptr = 0;
    else if (n > 0) mdl_ptr = (last + 1) % NF;
    @(posedge clock);
    #1;
    e   = sb.pop_front();
    got = {cdb_valid, cdb_rob_tag, cdb_value};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s lanes: got v=%b t=%h d=%h want v=%b t=%h d=%h", name,
               cdb_valid, cdb_rob_tag, cdb_value, e.valid, e.tag, e.val);
    end
    if (chk_ptr) begin
      checks++;
      if (int'(dut.rr_ptr_q) != exp_ptr) begin
        failures++;
        $display("FAIL %s rr_ptr: got %0d want %0d", name, dut.rr_ptr_q, exp_ptr);
      end
    end
  endtask

  initial begin
    int pend[NF];
    logic [NF-1:0] fdone;
    logic [NF-1:0] fack;

    reset = 1'b1; clear = 1'b0; fu_done = '0; fu_rob_tag = '0; fu_value = '0;

    add_vec(1, 0, 4'b1111, 5'd1,  32'h0000_0100, 4'b0000, 0);
    add_vec(1, 0, 4'b1111, 5'd1,  32'h0000_0100, 4'b0000, 0);
    add_vec(0, 0, 4'b1111, 5'd1,  32'h0000_1000, 4'b0011, 2);
    add_vec(0, 0, 4'b1100, 5'd1,  32'h0000_2000, 4'b1100, 0);
    add_vec(0, 0, 4'b1000, 5'd4,  32'h0000_DEAA, 4'b1000, 0);
    add_vec(0, 0, 4'b0000, 5'd9,  32'h1111_0000, 4'b0000, 0);
    add_vec(0, 0, 4'b0010, 5'd10, 32'h2222_0000, 4'b0010, 2);
    add_vec(0, 1, 4'b1111, 5'd12, 32'h3333_0000, 4'b0000, 0);
    add_vec(0, 0, 4'b0000, 5'd12, 32'h3333_0000, 4'b0000, 0);
    add_vec(0, 0, 4'b0100, 5'd16, 32'h4444_0000, 4'b0100, 3);
    add_vec(0, 0, 4'b1001, 5'd20, 32'h5555_0000, 4'b1001, 1);
    add_vec(0, 0, 4'b1111, 5'd24, 32'h6666_0000, 4'b0110, 3);
    add_vec(0, 0, 4'b1111, 5'd3,  32'h7777_0000, 4'b1001, 1);
    add_vec(0, 0, 4'b0001, 5'd8,  32'h8888_0000, 4'b0001, 1);
    add_vec(0, 0, 4'b0101, 5'd13, 32'h9999_0000, 4'b0101, 1);
    add_vec(0, 0, 4'b1110, 5'd17, 32'hAAAA_0000, 4'b0110, 3);
    add_vec(1, 0, 4'b0110, 5'd21, 32'hBBBB_0000, 4'b0000, 0);
    add_vec(0, 0, 4'b0001, 5'd26, 32'hCCCC_0000, 4'b0001, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].done, vecs[i].tag_base, vecs[i].val_base,
           vecs[i].exp_ack, 1'b1, vecs[i].exp_ptr, $sformatf("vec%0d", i));
    end

    // Fairness: FU0/FU1 re-assert every cycle while FU2 is held; nobody waits past 2.
    step(1, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1'b1, 0, "fair_rst");
    for (int i = 0; i < NF; i++) pend[i] = 0;
    for (int c = 0; c < 8; c++) begin
      fdone = 4'b0111;
      fack  = model_grant(fdone, mdl_ptr);
      step(0, 0, fdone, TW'(c), DW'(32'h5000 + c * 16), fack, 1'b0, 0,
           $sformatf("fair%0d", c));
      for (int i = 0; i < NF; i++) begin
        if (fdone[i]) begin
          pend[i]++;
          if (fack[i] || pend[i] > 2) begin
            checks++;
            if (pend[i] > 2) begin
              failures++;
              $display("FAIL fair FU%0d wait: got %0d want <=2", i, pend[i]);
            end
            pend[i] = 0;
          end
        end
      end
    end

    // Random traffic against the reference grant model.
    for (int c = 0; c < 40; c++) begin
      logic clr_r;
      fdone = NF'($urandom_range(0, 15));
      clr_r = ($urandom_range(0, 9) == 0);
      fack  = clr_r ? '0 : model_grant(fdone, mdl_ptr);
      step(0, clr_r, fdone, TW'($urandom), $urandom, fack, 1'b0, 0,
           $sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
